// File: rtl/lsu_data_port.sv
// Load/store data-port controller: one outstanding access, request/grant/response to data memory.
// Optional LSU_MISALIGN_TRAP_EN: reject misaligned accesses with misalign_o instead of force-aligning.
module lsu_data_port #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            acc_valid_i,
  input  logic            acc_store_i,
  input  logic [1:0]      acc_size_i,
  input  logic            acc_unsigned_i,
  input  logic [XLEN-1:0] acc_addr_i,
  input  logic [XLEN-1:0] acc_wdata_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state, state_next;
  logic            store_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [1:0]      lo_q;
  logic            mis_q;
  logic            drain_q;
  logic            req_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            accept;
  logic            mis_now;
  logic [1:0]      lo_eff;

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   calc_be = 4'b0001 << lo;
      2'b01:   calc_be = 4'b0011 << {lo[1], 1'b0};
      default: calc_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   calc_wdata = {4{data[7:0]}};
      2'b01:   calc_wdata = {2{data[15:0]}};
      default: calc_wdata = data;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  // Natural alignment of the low address bits; identity for already aligned accesses.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   align_lo = lo;
      2'b01:   align_lo = {lo[1], 1'b0};
      default: align_lo = 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic [1:0] lo, input logic uns);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    byte_sh = raw >> {lo, 3'b000};
    half_sh = raw >> {lo[1], 4'b0000};
    case (size)
      2'b00:   extend = {{24{~uns & byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   extend = {{16{~uns & half_sh[15]}}, half_sh[15:0]};
      default: extend = raw;
    endcase
  endfunction

  assign accept = (state == IDLE) && acc_valid_i && !flush_i;
  assign lo_eff = align_lo(acc_size_i, acc_addr_i[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_now = is_misaligned(acc_size_i, acc_addr_i[1:0]);
`else
  assign mis_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    misalign_o = 1'b0;
    case (state)
      IDLE: begin
        stall_o = acc_valid_i;
        if (accept) begin
          state_next = mis_now ? DONE : REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_next = IDLE;
        end else if (dmem_gnt_i) begin
          state_next = WAIT;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        // A flushed load/store still waits for its response so memory never sees an orphan.
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          state_next = (drain_q || flush_i) ? IDLE : DONE;
        end else begin
          state_next = WAIT;
        end
      end
      DONE: begin
        state_next = IDLE;
        if (mis_q) begin
          misalign_o = !flush_i;
        end else begin
          done_o = !flush_i;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      store_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lo_q    <= 2'b00;
      mis_q   <= 1'b0;
      drain_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            store_q <= acc_store_i;
            size_q  <= acc_size_i;
            uns_q   <= acc_unsigned_i;
            lo_q    <= lo_eff;
            mis_q   <= mis_now;
            drain_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
            if (!mis_now) begin
              req_q   <= 1'b1;
              we_q    <= acc_store_i;
              be_q    <= calc_be(acc_size_i, lo_eff);
              addr_q  <= {acc_addr_i[31:2], 2'b00};
              wdata_q <= acc_store_i ? calc_wdata(acc_size_i, acc_wdata_i) : 32'h0000_0000;
            end
          end
        end
        REQ: begin
          if (flush_i || dmem_gnt_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
          end
        end
        WAIT: begin
          if (flush_i) begin
            drain_q <= 1'b1;
          end
          if (dmem_rvalid_i && !store_q) begin
            rdata_q <= extend(dmem_rdata_i, size_q, lo_q, uns_q);
          end
        end
        default: begin
          drain_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Self-checking bench for lsu_data_port: directed spec scenarios plus randomized accesses
// checked against an arithmetic model of lanes, enables and extension.
module tb_lsu_data_port;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_valid_i, acc_store_i, acc_unsigned_i, flush_i;
  logic [1:0]  acc_size_i;
  logic [31:0] acc_addr_i, acc_wdata_i;
  logic        stall_o, dmem_req_o, dmem_we_o, done_o, misalign_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, rdata_o, dmem_rdata_i;
  logic        dmem_gnt_i, dmem_rvalid_i;

  int n_cmp = 0;
  int n_err = 0;

  lsu_data_port #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .acc_valid_i(acc_valid_i), .acc_store_i(acc_store_i), .acc_size_i(acc_size_i),
    .acc_unsigned_i(acc_unsigned_i), .acc_addr_i(acc_addr_i), .acc_wdata_i(acc_wdata_i),
    .flush_i(flush_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .done_o(done_o), .rdata_o(rdata_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   {31'd0, dmem_req_o}, 32'd0);
    chk({tag, "_we"},    {31'd0, dmem_we_o}, 32'd0);
    chk({tag, "_be"},    {28'd0, dmem_be_o}, 32'd0);
    chk({tag, "_addr"},  dmem_addr_o, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata_o, 32'd0);
    chk({tag, "_done"},  {31'd0, done_o}, 32'd0);
    chk({tag, "_mis"},   {31'd0, misalign_o}, 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
  endtask

  // Presents one access at a negedge, checks the accept-cycle stall, returns at the next negedge.
  task automatic accept(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd);
    acc_valid_i = 1'b1; acc_store_i = st; acc_size_i = sz; acc_unsigned_i = un;
    acc_addr_i = ad; acc_wdata_i = wd;
    #1;
    chk("stall_accept", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    acc_valid_i = 1'b0;
    acc_wdata_i = $urandom;
  endtask

  // Full access with gd grant-wait and rvd response-wait cycles, checked against the model.
  task automatic do_access(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                           input int gd, input int rvd);
    int nb, off;
    bit mis;
    logic [31:0] exp_be, exp_wd, exp_rd, mask;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(ad[1:0]);
    mis = (off % nb) != 0;
    if (!TRAP) off = off - (off % nb);
    exp_be = ((32'd1 << nb) - 32'd1) << off;
    exp_wd = 32'd0;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
    if (!st) exp_wd = 32'd0;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
    exp_rd = (rd >> (8*off)) & mask;
    if (!un && exp_rd[8*nb-1]) exp_rd = exp_rd | ~mask;
    if (st) exp_rd = 32'd0;

    accept(st, sz, un, ad, wd);
    if (TRAP && mis) begin
      chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
      chk("mis_nodone", {31'd0, done_o}, 32'd0);
      chk("mis_noreq", {31'd0, dmem_req_o}, 32'd0);
      chk("mis_stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      chk("mis_end", {31'd0, misalign_o}, 32'd0);
      chk("mis_end_req", {31'd0, dmem_req_o}, 32'd0);
    end else begin
      for (int c = 0; c <= gd; c++) begin
        chk("req", {31'd0, dmem_req_o}, 32'd1);
        chk("we", {31'd0, dmem_we_o}, {31'd0, st});
        chk("be", {28'd0, dmem_be_o}, exp_be);
        chk("addr", dmem_addr_o, {ad[31:2], 2'b00});
        chk("wdata", dmem_wdata_o, exp_wd);
        chk("stall_req", {31'd0, stall_o}, 32'd1);
        chk("done_early", {31'd0, done_o}, 32'd0);
        dmem_gnt_i = (c == gd);
        @(negedge clk);
      end
      dmem_gnt_i = 1'b0;
      for (int c = 0; c <= rvd; c++) begin
        chk("req_drop", {31'd0, dmem_req_o}, 32'd0);
        chk("stall_wait", {31'd0, stall_o}, 32'd1);
        chk("done_wait", {31'd0, done_o}, 32'd0);
        if (c == rvd) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i = rd;
        end
        @(negedge clk);
      end
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i = $urandom;
      chk("done", {31'd0, done_o}, 32'd1);
      chk("rdata", rdata_o, exp_rd);
      chk("stall_done", {31'd0, stall_o}, 32'd0);
      chk("mis_zero", {31'd0, misalign_o}, 32'd0);
      @(negedge clk);
      chk("done_pulse", {31'd0, done_o}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; acc_valid_i = 1'b0; acc_store_i = 1'b0; acc_size_i = 2'd0;
    acc_unsigned_i = 1'b0; acc_addr_i = 32'd0; acc_wdata_i = 32'd0; flush_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios
    do_access(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0);
    do_access(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 0);
    do_access(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'd0, 32'h80FF_0000, 1, 2);
    do_access(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'd0, 3, 1);
    do_access(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'd0, 32'hCAFE_F00D, 0, 0);
    do_access(1'b0, 2'd1, 1'b0, 32'h0000_0106, 32'd0, 32'h9ABC_1234, 0, 0);
    do_access(1'b0, 2'd3, 1'b0, 32'h0000_0104, 32'd0, 32'h0123_4567, 2, 0);

    // Flush while waiting for the response: drain silently, then a normal access
    accept(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'd0);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush_wait_done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    chk("drain_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    chk("drain_stall2", {31'd0, stall_o}, 32'd1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk("drain_nodone", {31'd0, done_o}, 32'd0);
    chk("drain_idle", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    chk("drain_nodone2", {31'd0, done_o}, 32'd0);
    do_access(1'b0, 2'd1, 1'b1, 32'h0000_0302, 32'd0, 32'hF00D_0000, 0, 1);

    // Flush while requesting: request dropped, no completion
    accept(1'b1, 2'd2, 1'b0, 32'h0000_0400, 32'h1111_2222);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flushreq_req", {31'd0, dmem_req_o}, 32'd0);
    chk("flushreq_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    chk("flushreq_done", {31'd0, done_o}, 32'd0);

    // Reset in WAIT, then a late response must be ignored
    accept(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'd0);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst_wait");
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    chk_all_zero("late_rvalid");
    do_access(1'b1, 2'd0, 1'b0, 32'h0000_0501, 32'h0000_00A5, 32'd0, 0, 0);

    // Randomized accesses
    for (int k = 0; k < 40; k++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                32'($urandom), 32'($urandom), 32'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
